// File: rtl/ex3_to_bcd_serial.sv
// rtl/ex3_to_bcd_serial.sv - bit-serial excess-3 to BCD decoder, LSB first
// Subtracts 0011 one bit at a time; the pending borrow is part of the FSM state.
module ex3_to_bcd_serial #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclr,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             out_valid,
  output logic             out_bit,
  output logic             out_last,
  output logic [3:0]       bcd_digit,
  output logic             digit_done,
  output logic             code_err,
  output logic [CNT_W-1:0] digit_cnt
);

  localparam logic [2:0] B0   = 3'd0;
  localparam logic [2:0] B1_N = 3'd1;
  localparam logic [2:0] B1_B = 3'd2;
  localparam logic [2:0] B2_N = 3'd3;
  localparam logic [2:0] B2_B = 3'd4;
  localparam logic [2:0] B3_N = 3'd5;
  localparam logic [2:0] B3_B = 3'd6;

  logic [2:0]       state_q, state_d, state_nxt;
  logic [2:0]       res_q, res_d, res_upd;
  logic             out_valid_q, out_bit_q, out_last_q;
  logic             digit_done_q, code_err_q;
  logic [3:0]       bcd_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             borrow_in, borrow_out;
  logic             d;
  logic             is_last;
  logic [3:0]       digit;
  logic             err;

  assign accept    = in_valid & ~sclr;
  assign borrow_in = (state_q == B1_B) || (state_q == B2_B) || (state_q == B3_B);

  // Bits 0 and 1 subtract a 1 (d = ~e ^ b), bits 2 and 3 subtract a 0 (d = e ^ b).
  always_comb begin
    d          = 1'b0;
    borrow_out = 1'b0;
    state_nxt  = B0;
    res_upd    = res_q;
    is_last    = 1'b0;
    case (state_q)
      B0: begin
        d          = ~in_bit;
        borrow_out = ~in_bit;
        state_nxt  = in_bit ? B1_N : B1_B;
        res_upd[0] = d;
      end
      B1_N, B1_B: begin
        d          = ~in_bit ^ borrow_in;
        borrow_out = ~in_bit | borrow_in;
        state_nxt  = borrow_out ? B2_B : B2_N;
        res_upd[1] = d;
      end
      B2_N, B2_B: begin
        d          = in_bit ^ borrow_in;
        borrow_out = ~in_bit & borrow_in;
        state_nxt  = borrow_out ? B3_B : B3_N;
        res_upd[2] = d;
      end
      B3_N, B3_B: begin
        d          = in_bit ^ borrow_in;
        borrow_out = ~in_bit & borrow_in;
        state_nxt  = B0;
        is_last    = 1'b1;
      end
      default: begin
        state_nxt = B0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    if (sclr) begin
      state_d = B0;
    end else if (in_valid) begin
      state_d = state_nxt;
      res_d   = res_upd;
    end
  end

  assign digit = {d, res_q};
  // Borrow out of bit 3 means input < 0011; a difference above 9 means input > 1100.
  assign err   = borrow_out | (digit > 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= B0;
      res_q        <= 3'b000;
      out_valid_q  <= 1'b0;
      out_bit_q    <= 1'b0;
      out_last_q   <= 1'b0;
      digit_done_q <= 1'b0;
      code_err_q   <= 1'b0;
      bcd_q        <= 4'd0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      res_q        <= res_d;
      out_valid_q  <= accept;
      out_last_q   <= accept & is_last;
      digit_done_q <= accept & is_last;
      code_err_q   <= accept & is_last & err;
      if (accept) begin
        out_bit_q <= d;
      end
      if (accept && is_last) begin
        bcd_q <= digit;
      end
      if (sclr) begin
        cnt_q <= '0;
      end else if (accept && is_last) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_bit    = out_bit_q;
  assign out_last   = out_last_q;
  assign digit_done = digit_done_q;
  assign code_err   = code_err_q;
  assign bcd_digit  = bcd_q;
  assign digit_cnt  = cnt_q;

endmodule

// File: tb/tb_ex3_to_bcd_serial.sv
// tb/tb_ex3_to_bcd_serial.sv - self-checking bench for ex3_to_bcd_serial
// Reference model works on whole digit values: result = (code - 3) mod 16.
module tb_ex3_to_bcd_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclr;
  logic       in_valid;
  logic       in_bit;

  logic       out_valid, out_bit, out_last, digit_done, code_err;
  logic [3:0] bcd_digit;
  logic [7:0] digit_cnt;

  logic       out_valid2, out_bit2, out_last2, digit_done2, code_err2;
  logic [3:0] bcd_digit2;
  logic [1:0] digit_cnt2;

  int         n_checks = 0;
  int         n_pass   = 0;

  int         m_pos, m_val, m_cnt;
  logic [3:0] m_bcd;
  logic       m_bit;

  always #5 clk = ~clk;

  ex3_to_bcd_serial #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .in_valid(in_valid), .in_bit(in_bit),
    .out_valid(out_valid), .out_bit(out_bit), .out_last(out_last),
    .bcd_digit(bcd_digit), .digit_done(digit_done), .code_err(code_err),
    .digit_cnt(digit_cnt)
  );

  ex3_to_bcd_serial #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .in_valid(in_valid), .in_bit(in_bit),
    .out_valid(out_valid2), .out_bit(out_bit2), .out_last(out_last2),
    .bcd_digit(bcd_digit2), .digit_done(digit_done2), .code_err(code_err2),
    .digit_cnt(digit_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_pos = 0; m_val = 0; m_cnt = 0; m_bcd = 4'd0; m_bit = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, out_valid, 0);
    check({tag, ".bit"},   out_bit,   0);
    check({tag, ".last"},  out_last,  0);
    check({tag, ".done"},  digit_done, 0);
    check({tag, ".err"},   code_err,  0);
    check({tag, ".bcd"},   bcd_digit, 0);
    check({tag, ".cnt"},   digit_cnt, 0);
    check({tag, ".cnt2"},  digit_cnt2, 0);
  endtask

  // One clock: drive at negedge, sample at the following negedge, compare with model.
  task automatic step(input logic v, input logic b, input logic clr);
    int  diff;
    logic exp_valid, exp_last, exp_err;
    in_valid = v; in_bit = b; sclr = clr;
    @(posedge clk);
    @(negedge clk);
    exp_valid = 1'b0; exp_last = 1'b0; exp_err = 1'b0;
    if (clr) begin
      m_pos = 0; m_val = 0; m_cnt = 0;
    end else if (v) begin
      m_val     = m_val | (int'(b) << m_pos);
      diff      = (m_val - 3) & 15;
      m_bit     = ((diff >> m_pos) & 1) != 0;
      exp_valid = 1'b1;
      if (m_pos == 3) begin
        exp_last = 1'b1;
        m_bcd    = 4'(diff);
        exp_err  = (m_val < 3) || (m_val > 12);
        m_cnt    = m_cnt + 1;
        m_pos    = 0;
        m_val    = 0;
      end else begin
        m_pos++;
      end
    end
    check("out_valid", out_valid, exp_valid);
    check("out_bit", out_bit, m_bit);
    check("out_last", out_last, exp_last);
    check("digit_done", digit_done, exp_last);
    check("code_err", code_err, exp_err);
    check("bcd_digit", bcd_digit, m_bcd);
    check("digit_cnt", digit_cnt, m_cnt % 256);
    check("digit_cnt_w2", digit_cnt2, m_cnt % 4);
    check("done_w2", digit_done2, exp_last);
    in_valid = 1'b0; sclr = 1'b0;
  endtask

  task automatic send_digit(input logic [3:0] val, input int maxgap);
    int gap;
    for (int i = 0; i < 4; i++) begin
      gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (gap) step(1'b0, 1'($urandom), 1'b0);
      step(1'b1, val[i], 1'b0);
    end
  endtask

  initial begin
    logic [3:0] code;
    rst_n = 1'b0; sclr = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    model_reset();
    #3;
    check_zero("reset");
    repeat (2) @(negedge clk);
    check_zero("reset_hold");
    rst_n = 1'b1;

    for (int v = 3; v <= 12; v++) send_digit(4'(v), 0);
    check("cnt_after_valid_codes", digit_cnt, 10);

    send_digit(4'b0000, 0);
    send_digit(4'b1101, 0);

    send_digit(4'b1000, 5);
    check("gapped_bcd", bcd_digit, 4'b0101);

    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    send_digit(4'b0100, 0);
    check("sclr_bcd", bcd_digit, 4'b0001);
    check("sclr_cnt", digit_cnt, 1);

    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk);
    check_zero("async_reset_hold");
    rst_n = 1'b1;
    model_reset();
    send_digit(4'b0110, 0);
    check("post_reset_bcd", bcd_digit, 4'b0011);
    check("post_reset_cnt", digit_cnt, 1);

    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) send_digit(4'($urandom_range(12, 3)), 0);
    check("w2_wrap", digit_cnt2, 1);

    for (int i = 0; i < 40; i++) begin
      code = 4'($urandom);
      if ($urandom_range(9, 0) == 0) step(1'b1, 1'($urandom), 1'b1);
      send_digit(code, $urandom_range(2, 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
